// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths and helper functions for the 8-to-3 priority
// encoder.
//   N_IN      number of request lines
//   W_IDX     width of the binary index
//   enc_out_t registered output bundle {idx, valid, err}
//   prio_idx  index of the highest set bit (0 when no bit is set)
//   multi_hot 1 when two or more bits are set
package encoder_pkg;

  localparam int N_IN  = 8;
  localparam int W_IDX = 3;

  typedef struct packed {
    logic [W_IDX-1:0] idx;
    logic             valid;
    logic             err;
  } enc_out_t;

  // Ascending scan, so the last (highest) set bit overwrites lower ones.
  function automatic logic [W_IDX-1:0] prio_idx(input logic [N_IN-1:0] vec);
    logic [W_IDX-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (vec[k]) idx = W_IDX'(k);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if a second bit was set.
  function automatic logic multi_hot(input logic [N_IN-1:0] vec);
    return (vec & (vec - N_IN'(1))) != '0;
  endfunction

endpackage

// File: rtl/encoder_core.sv
// encoder_core: purely combinational priority encode of an 8-bit request
// vector.
//   vec_i   [7:0]  request vector, bit k = request k
//   idx_o   [2:0]  index of highest asserted request (0 when none)
//   valid_o        at least one request asserted
//   err_o          two or more requests asserted
module encoder_core
  import encoder_pkg::*;
(
  input  logic [N_IN-1:0]  vec_i,
  output logic [W_IDX-1:0] idx_o,
  output logic             valid_o,
  output logic             err_o
);

  always_comb begin
    idx_o   = prio_idx(vec_i);
    valid_o = |vec_i;
    // Independent of the priority selection.
    err_o   = multi_hot(vec_i);
  end

endmodule

// File: rtl/encoder.sv
// encoder: registered 8-to-3 priority encoder with valid and multi-hot error
// flags. All outputs appear one clk cycle after the inputs are sampled.
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (outputs clear immediately)
//   D0..D7    request lines, Dk means "index k", D7 highest priority
//   A2..A0    registered binary index (A0 = LSB)
//   V         registered: at least one Dk asserted
//   ERR       registered: two or more Dk asserted
module encoder
  import encoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic D5,
  input  logic D6,
  input  logic D7,
  output logic A0,
  output logic A1,
  output logic A2,
  output logic V,
  output logic ERR
);

  logic [N_IN-1:0]  req_vec;
  logic [W_IDX-1:0] core_idx;
  logic             core_valid;
  logic             core_err;
  enc_out_t         out_d;
  enc_out_t         out_q;

  assign req_vec = {D7, D6, D5, D4, D3, D2, D1, D0};

  encoder_core u_core (
    .vec_i   (req_vec),
    .idx_o   (core_idx),
    .valid_o (core_valid),
    .err_o   (core_err)
  );

  always_comb begin
    out_d.idx   = core_idx;
    out_d.valid = core_valid;
    out_d.err   = core_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign {A2, A1, A0} = out_q.idx;
  assign V            = out_q.valid;
  assign ERR          = out_q.err;

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: scoreboard bench for the registered priority encoder.
module tb_encoder;

  logic clk;
  logic rst;
  logic [7:0] d;
  logic A0, A1, A2, V, ERR;

  encoder dut (
    .clk (clk), .rst (rst),
    .D0 (d[0]), .D1 (d[1]), .D2 (d[2]), .D3 (d[3]),
    .D4 (d[4]), .D5 (d[5]), .D6 (d[6]), .D7 (d[7]),
    .A0 (A0), .A1 (A1), .A2 (A2), .V (V), .ERR (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected word layout: {idx[2:0], valid, err}
  logic [4:0] exp_q[$];
  logic [4:0] last_exp;
  logic       hold_ok;
  int         n_cmp;
  int         n_bad;

  function automatic logic [4:0] model(input logic [7:0] v);
    int hi;
    int cnt;
    hi  = 0;
    cnt = 0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) begin
        cnt++;
        if (cnt == 1) hi = k;
      end
    end
    return {3'(hi), cnt > 0, cnt > 1};
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {A2, A1, A0, V, ERR};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got A=%b V=%b ERR=%b, want A=%b V=%b ERR=%b",
               name, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive one input pattern between edges and record what the next edge owes.
  task automatic apply(input logic [7:0] v);
    @(negedge clk);
    d = v;
    exp_q.push_back(model(v));
  endtask

  task automatic drain();
    int budget;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expected results never produced", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: outputs are presented once per edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", e);
        last_exp = e;
        hold_ok  = 1'b1;
      end else begin
        hold_ok = 1'b0;
      end
    end
  end

  // Mid-cycle check, after the inputs have already moved for the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (hold_ok && !rst) check("hold_between_edges", last_exp);
    end
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    hold_ok = 1'b0;
    last_exp = '0;
    rst = 1'b0;
    d   = 8'hFF;

    // Async reset before any clock edge.
    #2 rst = 1'b1;
    #1 check("reset_async", 5'b000_0_0);
    @(posedge clk);
    #1 check("reset_held", 5'b000_0_0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(5'b111_1_1);
    drain();

    apply(8'h00);

    for (int k = 0; k < 8; k++) apply(8'(1 << k));

    apply(8'b0010_1000);
    apply(8'b1000_0001);
    apply(8'b0000_0110);

    // Latency: back-to-back changes, no bubbles.
    apply(8'b0000_0100);
    apply(8'b0100_0000);
    drain();

    // Mid-operation reset with D5 steady.
    apply(8'b0010_0000);
    apply(8'b0010_0000);
    drain();
    @(negedge clk);
    hold_ok = 1'b0;
    #1 check("pre_reset", 5'b101_1_0);
    #1 rst = 1'b1;
    #1 check("reset_mid_op", 5'b000_0_0);
    d = 8'hC3;
    #1 check("reset_mid_op_held", 5'b000_0_0);
    d = 8'b0010_0000;
    rst = 1'b0;
    exp_q.push_back(model(d));
    drain();

    // Randomized traffic, biased toward empty and one-hot patterns.
    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [7:0] v;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      v = 8'h00;
      else if (sel < 4)  v = 8'(1 << $urandom_range(0, 7));
      else               v = 8'($urandom_range(0, 255));
      apply(v);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
